axi_burst_writer: RTL and testbench

Parametrised AXI4 write-burst master: the next generation of the team's fixed 256-beat, 32-bit write master. It issues one INCR burst per `start` request: address phase on AW, a fully handshaked W channel fed from an upstream valid/ready stream, then collection of the B response. Data width, address width and burst length are parameters. The block sits between a local data producer (FIFO or DMA front end) and the AXI interconnect slave port.

---
 rtl/axi_burst_writer.sv | 187 ++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: issues one AXI4 INCR write burst per start request.
// The address phase completes before any data. W beats flow from an upstream
// valid/ready stream through a one-entry output register. The B response is
// collected last and reported with done/err pulses.
module axi_burst_writer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] M_AWADDR,
    output logic [7:0]        M_AWLEN,
    output logic              M_AWVALID,
    input  logic              S_AWREADY,
    output logic [DATA_W-1:0] M_WDATA,
    output logic              M_WLAST,
    output logic              M_WVALID,
    input  logic              S_WREADY,
    input  logic              BVALID,
    input  logic [1:0]        BRESP,
    output logic              BREADY,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic              bready_q, bready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  loaded_q, loaded_d;
    logic [CNT_W-1:0]  sent_q, sent_d;

    logic din_ready_s;
    logic load_s;
    logic w_hs_s;

    // The output register may refill in the same cycle it drains, so a new
    // beat is accepted whenever the register is empty or being handshaked.
    assign din_ready_s = (state_q == ST_DATA) && (loaded_q < LEN_C) && (!wvalid_q || S_WREADY);
    assign load_s      = din_valid && din_ready_s;
    assign w_hs_s      = wvalid_q && S_WREADY;

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        awvalid_d = awvalid_q;
        wdata_d   = wdata_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        loaded_d  = loaded_q;
        sent_d    = sent_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    awaddr_d  = start_addr;
                    awvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (S_AWREADY) begin
                    awvalid_d = 1'b0;
                    loaded_d  = {CNT_W{1'b0}};
                    sent_d    = {CNT_W{1'b0}};
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (load_s) begin
                    wdata_d  = din;
                    wvalid_d = 1'b1;
                    wlast_d  = (loaded_q == LAST_C);
                    loaded_d = loaded_q + ONE_C;
                end else if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (w_hs_s) begin
                    sent_d = sent_q + ONE_C;
                    if (sent_q == LAST_C) begin
                        bready_d = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (BVALID) begin
                    done_d   = 1'b1;
                    err_d    = (BRESP != 2'b00);
                    bready_d = 1'b0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            awaddr_q  <= {ADDR_W{1'b0}};
            awvalid_q <= 1'b0;
            wdata_q   <= {DATA_W{1'b0}};
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            loaded_q  <= {CNT_W{1'b0}};
            sent_q    <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awvalid_q <= awvalid_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            loaded_q  <= loaded_d;
            sent_q    <= sent_d;
        end
    end

    assign din_ready = din_ready_s;
    assign M_AWADDR  = awaddr_q;
    assign M_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WLAST   = wlast_q;
    assign M_WVALID  = wvalid_q;
    assign BREADY    = bready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Directed bench for axi_burst_writer: three instances (4-, 256- and 1-beat
// bursts) share the slave-side inputs, and only one is started at a time.
module tb_axi_burst_writer;

    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] start_addr;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          aw_ready;
    logic          w_ready;
    logic          bvalid;
    logic [1:0]    bresp;
    logic [2:0]    start;

    logic          din_ready [3];
    logic [AW-1:0] awaddr    [3];
    logic [7:0]    awlen     [3];
    logic          awvalid   [3];
    logic [DW-1:0] wdata     [3];
    logic          wlast     [3];
    logic          wvalid    [3];
    logic          bready    [3];
    logic          busy      [3];
    logic          done      [3];
    logic          err       [3];

    axi_burst_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .start_addr(start_addr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
        .M_AWADDR(awaddr[0]), .M_AWLEN(awlen[0]), .M_AWVALID(awvalid[0]), .S_AWREADY(aw_ready),
        .M_WDATA(wdata[0]), .M_WLAST(wlast[0]), .M_WVALID(wvalid[0]), .S_WREADY(w_ready),
        .BVALID(bvalid), .BRESP(bresp), .BREADY(bready[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]));

    axi_burst_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(256)) u_dut256 (
        .clk(clk), .rst(rst), .start(start[1]), .start_addr(start_addr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
        .M_AWADDR(awaddr[1]), .M_AWLEN(awlen[1]), .M_AWVALID(awvalid[1]), .S_AWREADY(aw_ready),
        .M_WDATA(wdata[1]), .M_WLAST(wlast[1]), .M_WVALID(wvalid[1]), .S_WREADY(w_ready),
        .BVALID(bvalid), .BRESP(bresp), .BREADY(bready[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]));

    axi_burst_writer #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[2]), .start_addr(start_addr),
        .din(din), .din_valid(din_valid), .din_ready(din_ready[2]),
        .M_AWADDR(awaddr[2]), .M_AWLEN(awlen[2]), .M_AWVALID(awvalid[2]), .S_AWREADY(aw_ready),
        .M_WDATA(wdata[2]), .M_WLAST(wlast[2]), .M_WVALID(wvalid[2]), .S_WREADY(w_ready),
        .BVALID(bvalid), .BRESP(bresp), .BREADY(bready[2]),
        .busy(busy[2]), .done(done[2]), .err(err[2]));

    int checks   = 0;
    int failures = 0;

    int            act;          // index of the instance currently exercised
    int            cyc_n;
    int            aw_cnt, aw_cyc;
    logic [AW-1:0] aw_addr_seen;
    int            done_cnt, done_cyc, err_cnt, err_cyc;
    logic          busy_at_done;
    logic          stalled_prev;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [DW-1:0] hs_data [$];
    logic          hs_last [$];
    int            hs_cyc  [$];
    logic [DW-1:0] base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        hs_data.delete();
        hs_last.delete();
        hs_cyc.delete();
        aw_cnt       = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        stalled_prev = 1'b0;
    endtask

    // One clock: observe the active instance at the falling edge, then
    // advance past the rising edge. din steps to the next value after a load.
    task automatic cycle();
        logic ld;
        @(negedge clk);
        cyc_n++;
        if (awvalid[act] && aw_ready) begin
            aw_cnt++;
            aw_cyc       = cyc_n;
            aw_addr_seen = awaddr[act];
        end
        if (stalled_prev) begin
            chk("w_hold_valid", wvalid[act], 1'b1);
            chk("w_hold_data", wdata[act], hold_data);
            chk("w_hold_last", wlast[act], hold_last);
        end
        if (wvalid[act] && !w_ready) begin
            chk("din_ready_in_stall", din_ready[act], 1'b0);
        end
        stalled_prev = wvalid[act] && !w_ready;
        hold_data    = wdata[act];
        hold_last    = wlast[act];
        if (wvalid[act] && w_ready) begin
            hs_data.push_back(wdata[act]);
            hs_last.push_back(wlast[act]);
            hs_cyc.push_back(cyc_n);
        end
        if (done[act]) begin
            done_cnt++;
            done_cyc     = cyc_n;
            busy_at_done = busy[act];
        end
        if (err[act]) begin
            err_cnt++;
            err_cyc = cyc_n;
        end
        ld = din_valid && din_ready[act];
        @(posedge clk);
        #1;
        if (ld) din = din + 32'd1;
    endtask

    task automatic issue_start(input int idx, input logic [AW-1:0] addr);
        start_addr = addr;
        start[idx] = 1'b1;
        cycle();
        start[idx] = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("done_within_budget", (done_cnt != 0), 1'b1);
    endtask

    task automatic check_burst(input string tag, input int n, input logic [DW-1:0] first);
        chk({tag, "_beats"}, hs_data.size(), n);
        for (int i = 0; i < n && i < hs_data.size(); i++) begin
            chk({tag, "_data"}, hs_data[i], first + DW'(i));
            chk({tag, "_last"}, hs_last[i], (i == n - 1));
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 3'b000;
        start_addr = 32'h0;
        din        = 32'd1;
        din_valid  = 1'b0;
        aw_ready   = 1'b0;
        w_ready    = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'b00;
        act        = 0;
        cyc_n      = 0;
        clear_log();

        // Reset state of every instance.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_awvalid", awvalid[i], 1'b0);
            chk("rst_wvalid", wvalid[i], 1'b0);
            chk("rst_bready", bready[i], 1'b0);
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_awaddr", awaddr[i], 32'h0);
        end
        chk("rst_wdata", wdata[0], 32'h0);
        chk("rst_done", done[0], 1'b0);
        chk("awlen_4", awlen[0], 8'd3);
        chk("awlen_256", awlen[1], 8'd255);
        chk("awlen_1", awlen[2], 8'd0);
        rst = 1'b0;
        cycle();

        // 4-beat burst, everything ready: back-to-back beats 1..4.
        act       = 0;
        aw_ready  = 1'b1;
        w_ready   = 1'b1;
        bvalid    = 1'b1;
        din_valid = 1'b1;
        din       = 32'd1;
        clear_log();
        issue_start(0, 32'h0000_1000);
        chk("t1_awvalid_after_start", awvalid[0], 1'b1);
        chk("t1_busy_after_start", busy[0], 1'b1);
        run_until_done(50);
        chk("t1_aw_count", aw_cnt, 1);
        chk("t1_aw_addr", aw_addr_seen, 32'h0000_1000);
        check_burst("t1", 4, 32'd1);
        if (hs_cyc.size() == 4) begin
            chk("t1_beats_consecutive", hs_cyc[3] - hs_cyc[0], 3);
            chk("t1_last_beat_latency", hs_cyc[3] - aw_cyc, 5);
        end
        chk("t1_done_latency", done_cyc - aw_cyc, 7);
        chk("t1_done_count", done_cnt, 1);
        chk("t1_err_count", err_cnt, 0);
        chk("t1_busy_at_done", busy_at_done, 1'b0);

        // AW stalled 5 cycles, SLVERR response, stray start during DATA.
        clear_log();
        aw_ready = 1'b0;
        bresp    = 2'b10;
        issue_start(0, 32'h0000_2000);
        for (int k = 0; k < 5; k++) begin
            chk("t3_awvalid_held", awvalid[0], 1'b1);
            chk("t3_awaddr_held", awaddr[0], 32'h0000_2000);
            chk("t3_no_din_ready", din_ready[0], 1'b0);
            chk("t3_no_wvalid", wvalid[0], 1'b0);
            cycle();
        end
        aw_ready = 1'b1;
        cycle();
        chk("t3_data_after_aw", din_ready[0], 1'b1);
        chk("t3_awvalid_dropped", awvalid[0], 1'b0);
        issue_start(0, 32'h0000_9000);
        run_until_done(50);
        repeat (10) cycle();
        check_burst("t4", 4, 32'd5);
        chk("t4_aw_count", aw_cnt, 1);
        chk("t4_done_count", done_cnt, 1);
        chk("t4_err_count", err_cnt, 1);
        chk("t4_err_with_done", err_cyc, done_cyc);
        chk("t4_idle_after", busy[0], 1'b0);
        bresp = 2'b00;

        // 256-beat burst with random W backpressure and gapped input.
        act = 1;
        clear_log();
        din  = 32'h0000_0100;
        base = din;
        issue_start(1, 32'h0000_8000);
        for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
            w_ready   = ($urandom_range(0, 2) != 0);
            din_valid = ($urandom_range(0, 3) != 0);
            cycle();
        end
        chk("t2_done_count", done_cnt, 1);
        chk("t2_aw_addr", aw_addr_seen, 32'h0000_8000);
        check_burst("t2", 256, base);
        w_ready   = 1'b1;
        din_valid = 1'b1;

        // Single-beat burst carries WLAST on its only beat.
        act = 2;
        clear_log();
        base = din;
        issue_start(2, 32'h0000_3000);
        run_until_done(20);
        chk("t5_aw_addr", aw_addr_seen, 32'h0000_3000);
        check_burst("t5", 1, base);
        chk("t5_err_count", err_cnt, 0);

        // Reset while a beat is stalled on W, then a clean fresh burst.
        act = 1;
        clear_log();
        w_ready = 1'b0;
        issue_start(1, 32'h0000_4000);
        for (int n = 0; n < 20 && !wvalid[1]; n++) cycle();
        chk("t6_wvalid_before_rst", wvalid[1], 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_wvalid", wvalid[1], 1'b0);
        chk("t6_rst_wlast", wlast[1], 1'b0);
        chk("t6_rst_wdata", wdata[1], 32'h0);
        chk("t6_rst_awvalid", awvalid[1], 1'b0);
        chk("t6_rst_awaddr", awaddr[1], 32'h0);
        chk("t6_rst_bready", bready[1], 1'b0);
        chk("t6_rst_busy", busy[1], 1'b0);
        chk("t6_rst_din_ready", din_ready[1], 1'b0);
        stalled_prev = 1'b0;
        cycle();
        rst = 1'b0;
        clear_log();
        w_ready = 1'b1;
        base    = din;
        issue_start(1, 32'h0000_5000);
        run_until_done(400);
        chk("t6_aw_count", aw_cnt, 1);
        chk("t6_aw_addr", aw_addr_seen, 32'h0000_5000);
        check_burst("t6", 256, base);
        chk("t6_done_count", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
